// File: rtl/alu_result_stage.sv
// Writeback register stage behind the 8-bit ALU: captures result and flags, keeps the status register,
// and feeds the register-file write port through a 2-entry skid buffer with a registered in_ready.
module alu_result_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    input  logic             in_overflow,
    input  logic             in_flag_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [3:0]       status
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Entry layout: {result, N, Z, C, V}
    logic [WIDTH+3:0] head_q, head_d;
    logic [WIDTH+3:0] skid_q, skid_d;
    logic [3:0]       status_q, status_d;

    logic             accept;
    logic             pop;
    logic [3:0]       new_flags;
    logic [WIDTH+3:0] new_entry;

    always_comb begin
        accept = in_valid && (state_q != TWO);
        pop    = (state_q != EMPTY) && out_ready;
        // A non-writing op inherits status_q, which already reflects a flag write on the previous edge.
        if (in_flag_we) begin
            new_flags = {in_result[WIDTH-1], (in_result == '0), in_carry, in_overflow};
        end else begin
            new_flags = status_q;
        end
        new_entry = {in_result, new_flags};
    end

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        skid_d   = skid_q;
        status_d = status_q;

        if (accept && in_flag_we) begin
            status_d = new_flags;
        end

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_d  = new_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    head_d = new_entry;
                end else if (accept) begin
                    skid_d  = new_entry;
                    state_d = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            head_q   <= '0;
            skid_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            skid_q   <= skid_d;
            status_q <= status_d;
        end
    end

    assign in_ready   = (state_q != TWO);
    assign out_valid  = (state_q != EMPTY);
    assign out_result = head_q[WIDTH+3:4];
    assign out_flags  = head_q[3:0];
    assign status     = status_q;

endmodule
